multi_counter_hub: RTL and testbench

Parametrised event/timer counting hub feeding the seven-segment display path. Per channel: conditions NUM_CH raw bouncy button inputs (synchroniser, debounce, rising edge) and counts the edges. Also runs one stopwatch channel driven by an internal periodic tick, with start/stop and lap capture. A registered source mux produces the 32-bit display word; wrap/saturate counting and sticky overflow flags are added.

---
 rtl/multi_counter_pkg.sv | 35 +++
 rtl/multi_counter_hub_event_conditioner.sv | 58 +++++
 rtl/multi_counter_hub.sv | 163 ++++++++++++++++
 tb/tb_multi_counter_hub.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_counter_pkg.sv
// Shared constants, stopwatch state type and the wrap/saturate increment helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package multi_counter_pkg;

    localparam int DISP_W = 32;
    localparam int HALF_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic {
        SW_STOPPED = 1'b0,
        SW_RUNNING = 1'b1
    } sw_state_t;

    typedef struct packed {
        logic [HALF_W-1:0] value;
        logic              ovf;
    } inc_t;

    // Increment that either wraps to zero or sticks at max; ovf flags the attempt past max.
    function automatic inc_t sat_inc(input logic [HALF_W-1:0] value,
                                     input logic [HALF_W-1:0] max,
                                     input logic              sat);
        inc_t r;
        if (value == max) begin
            r.ovf   = 1'b1;
            r.value = sat ? max : '0;
        end else begin
            r.ovf   = 1'b0;
            r.value = value + HALF_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_counter_hub_event_conditioner.sv
// Synchroniser + debouncer + rising-edge detector for one raw bouncy input.
// Latency: rise_out asserts 2 + DB_CYCLES cycles after the first sampling edge of a clean step.
// Backpressure: none; free-running, a bounce shorter than DB_CYCLES is simply absorbed.
module event_conditioner #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic evt_in,
    output logic rise_out
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          clean_q;
    logic          clean_d_q;
    logic [CW-1:0] stable_cnt_q;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], evt_in};
        end
    end

    // Accept the synchronised level only after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clean_q      <= 1'b0;
            stable_cnt_q <= '0;
        end else if (sync_q[1] != clean_q) begin
            if (stable_cnt_q == DB_LAST) begin
                clean_q      <= sync_q[1];
                stable_cnt_q <= '0;
            end else begin
                stable_cnt_q <= stable_cnt_q + CW'(1);
            end
        end else begin
            stable_cnt_q <= '0;
        end
    end

    // Delayed copy of the clean level for edge detection.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clean_d_q <= 1'b0;
        end else begin
            clean_d_q <= clean_q;
        end
    end

    assign rise_out = clean_q & ~clean_d_q;

endmodule

// File: rtl/multi_counter_hub.sv
// Event counters on debounced inputs plus a tick-driven stopwatch, muxed into a 32-bit display word.
// Latency: count updates one cycle after rise/tick; val_out is registered one cycle after sel/count.
// Backpressure: none; every rise and tick is counted (or saturates/wraps with a sticky overflow flag).
module multi_counter_hub
    import multi_counter_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int TICK_PERIOD = 10_000_000,
    parameter int DB_CYCLES   = 1_000_000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] evt_in,
    input  logic              clr_in,
    input  logic              run_tgl_in,
    input  logic              lap_in,
    input  logic              sat_in,
    input  logic [SEL_W-1:0]  sel_in,
    output logic              tick_out,
    output logic              running_out,
    output logic [NUM_CH:0]   ovf_out,
    output logic [DISP_W-1:0] val_out
);

    localparam int PW = $clog2(TICK_PERIOD);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_PERIOD - 1);
    localparam logic [HALF_W-1:0] CNT_MAX    = HALF_W'((32'd1 << CNT_W) - 32'd1);

    logic [NUM_CH-1:0] rise;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] evt_ovf_q;
    inc_t              evt_inc [NUM_CH];

    logic [PW-1:0]     presc_q;
    sw_state_t         sw_state_q;
    sw_state_t         sw_state_d;
    logic [CNT_W-1:0]  sw_cnt_q;
    logic [CNT_W-1:0]  lap_q;
    logic              sw_ovf_q;
    inc_t              sw_inc;
    logic [DISP_W-1:0] disp_d;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_cond
            event_conditioner #(
                .DB_CYCLES (DB_CYCLES)
            ) u_cond (
                .clk_in   (clk_in),
                .rst_in   (rst_in),
                .evt_in   (evt_in[g]),
                .rise_out (rise[g])
            );
        end
    endgenerate

    // Next value of every event counter, computed at the common 16-bit width.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            evt_inc[i] = sat_inc(HALF_W'(cnt_q[i]), CNT_MAX, sat_in);
        end
    end

    // Event counters and their sticky overflow flags; clear beats increment.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            evt_ovf_q <= '0;
        end else if (clr_in) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            evt_ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rise[i]) begin
                    cnt_q[i] <= CNT_W'(evt_inc[i].value);
                    if (evt_inc[i].ovf) evt_ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    // Free-running prescaler; untouched by clear or run state so the tick phase never slips.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign tick_out = (presc_q == PRESC_LAST);

    // Stopwatch run-state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sw_state_q <= SW_STOPPED;
        end else begin
            sw_state_q <= sw_state_d;
        end
    end

    // Stopwatch next state: each toggle pulse flips between stopped and running.
    always_comb begin
        sw_state_d = sw_state_q;
        if (run_tgl_in) begin
            sw_state_d = (sw_state_q == SW_RUNNING) ? SW_STOPPED : SW_RUNNING;
        end
    end

    // Stopwatch outputs come from the current state, so a coincident toggle affects the next tick only.
    always_comb begin
        running_out = (sw_state_q == SW_RUNNING);
    end

    assign sw_inc = sat_inc(HALF_W'(sw_cnt_q), CNT_MAX, sat_in);

    // Stopwatch count, lap capture and stopwatch overflow flag; lap sees the pre-increment count.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sw_cnt_q <= '0;
            lap_q    <= '0;
            sw_ovf_q <= 1'b0;
        end else if (clr_in) begin
            sw_cnt_q <= '0;
            lap_q    <= '0;
            sw_ovf_q <= 1'b0;
        end else begin
            if (tick_out && running_out) begin
                sw_cnt_q <= CNT_W'(sw_inc.value);
                if (sw_inc.ovf) sw_ovf_q <= 1'b1;
            end
            if (lap_in) lap_q <= sw_cnt_q;
        end
    end

    assign ovf_out = {sw_ovf_q, evt_ovf_q};

    // Display source select: channel id + count, lap + stopwatch, or zero when out of range.
    always_comb begin
        disp_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_in == SEL_W'(i)) begin
                disp_d = {HALF_W'(i), HALF_W'(cnt_q[i])};
            end
        end
        if (sel_in == SEL_W'(NUM_CH)) begin
            disp_d = {HALF_W'(lap_q), HALF_W'(sw_cnt_q)};
        end
    end

    // Registered display word.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            val_out <= '0;
        end else begin
            val_out <= disp_d;
        end
    end

endmodule

// File: tb/tb_multi_counter_hub.sv
module tb_multi_counter_hub;

    logic        clk;
    logic        rst;
    logic [3:0]  evt;
    logic        clr;
    logic        run_tgl;
    logic        lap;
    logic        sat;
    logic [3:0]  sel;
    logic        tick;
    logic        running;
    logic [4:0]  ovf;
    logic [31:0] val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          do_press;
        int          ch;
        logic [3:0]  sel;
        logic [31:0] exp_val;
        logic [4:0]  exp_ovf;
    } vec_t;

    vec_t vecs [8];

    multi_counter_hub #(
        .NUM_CH      (4),
        .CNT_W       (4),
        .TICK_PERIOD (10),
        .DB_CYCLES   (4)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .evt_in      (evt),
        .clr_in      (clr),
        .run_tgl_in  (run_tgl),
        .lap_in      (lap),
        .sat_in      (sat),
        .sel_in      (sel),
        .tick_out    (tick),
        .running_out (running),
        .ovf_out     (ovf),
        .val_out     (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int ch);
        evt[ch] = 1'b1;
        cyc(10);
        evt[ch] = 1'b0;
        cyc(10);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tick_align", 32'(tick), 32'd1);
    endtask

    initial begin
        int tick_cnt;

        vecs[0] = '{1'b1, 3, 4'd3,  32'h0003_0001, 5'b00000};
        vecs[1] = '{1'b1, 3, 4'd3,  32'h0003_0002, 5'b00000};
        vecs[2] = '{1'b1, 0, 4'd0,  32'h0000_0002, 5'b00000};
        vecs[3] = '{1'b1, 1, 4'd1,  32'h0001_0002, 5'b00000};
        vecs[4] = '{1'b0, 0, 4'd2,  32'h0002_0000, 5'b00000};
        vecs[5] = '{1'b0, 0, 4'd4,  32'h0000_0000, 5'b00000};
        vecs[6] = '{1'b0, 0, 4'd5,  32'h0000_0000, 5'b00000};
        vecs[7] = '{1'b0, 0, 4'd15, 32'h0000_0000, 5'b00000};

        rst = 1'b1; evt = '0; clr = 0; run_tgl = 0; lap = 0; sat = 0; sel = 4'd1;
        cyc(3);
        chk("rst_val", val, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Clean step on channel 1: count at 7th edge, display one edge later.
        evt[1] = 1'b1;
        cyc(7);
        chk("lat_before_disp", val, 32'h0001_0000);
        cyc(1);
        chk("lat_disp", val, 32'h0001_0001);
        cyc(20);
        chk("hold_no_extra", val, 32'h0001_0001);
        evt[1] = 1'b0;
        cyc(10);

        // Bounce on channel 0 then settle high.
        sel = 4'd0;
        for (int k = 0; k < 6; k++) begin
            evt[0] = (k % 2 == 0);
            cyc(2);
        end
        evt[0] = 1'b1;
        cyc(20);
        chk("bounce_one", val, 32'h0000_0001);
        evt[0] = 1'b0;
        cyc(10);

        // Table of presses and display selections.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_press) press(vecs[v].ch);
            sel = vecs[v].sel;
            cyc(2);
            chk($sformatf("vec%0d_val", v), val, vecs[v].exp_val);
            chk($sformatf("vec%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
        end

        // Wrap then saturate on channel 2.
        sat = 1'b0;
        for (int p = 0; p < 17; p++) press(2);
        sel = 4'd2;
        cyc(2);
        chk("wrap_val", val, 32'h0002_0001);
        chk("wrap_ovf", 32'(ovf), 32'h04);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(2);
        chk("clr_val", val, 32'h0002_0000);
        chk("clr_ovf", 32'(ovf), 32'h00);
        sat = 1'b1;
        for (int p = 0; p < 17; p++) press(2);
        cyc(2);
        chk("sat_val", val, 32'h0002_000F);
        chk("sat_ovf", 32'(ovf), 32'h04);
        sat = 1'b0;

        // Stopwatch: start on a tick edge (tick uses the stopped state), run 55 edges, lap + stop.
        sel = 4'd4;
        wait_tick();
        run_tgl = 1'b1;
        cyc(1);
        run_tgl = 1'b0;
        chk("sw_running", 32'(running), 32'd1);
        tick_cnt = 0;
        for (int k = 0; k < 54; k++) begin
            @(negedge clk);
            if (tick === 1'b1) tick_cnt++;
        end
        chk("tick_count", 32'(tick_cnt), 32'd5);
        chk("sw_count5", val, 32'h0000_0005);
        lap = 1'b1;
        run_tgl = 1'b1;
        cyc(1);
        lap = 1'b0;
        run_tgl = 1'b0;
        cyc(30);
        chk("sw_lap_frozen", val, 32'h0005_0005);
        chk("sw_stopped", 32'(running), 32'd0);

        // Clear coinciding with rise[3] and a running tick.
        wait_tick();
        run_tgl = 1'b1;
        cyc(1);
        run_tgl = 1'b0;
        cyc(3);
        evt[3] = 1'b1;
        cyc(6);
        chk("coinc_tick", 32'(tick), 32'd1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("coinc_ovf", 32'(ovf), 32'd0);
        chk("coinc_running", 32'(running), 32'd1);
        sel = 4'd3;
        cyc(2);
        chk("coinc_ch3", val, 32'h0003_0000);
        sel = 4'd4;
        cyc(2);
        chk("coinc_sw", val, 32'h0000_0000);
        cyc(10);
        chk("sw_after_clr", val, 32'h0000_0001);

        // Asynchronous reset between edges.
        evt = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_val", val, 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sel = 4'd9;
        cyc(2);
        chk("sel9_val", val, 32'd0);
        chk("post_rst_running", 32'(running), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
